mod3_overlap_add: RTL and testbench
===================================

# mod3_overlap_add

Parametrised AXI-Stream overlap-add stage for the module-3 packet datapath. Each fixed-length packet has its first OVERLAP_K samples summed with the last OVERLAP_K raw samples of the previous packet. It generalises the earlier fixed 8-bit/K=3 adder by adding:
- full valid/ready backpressure;
- ping-pong history banks, so any K ≤ PKT_LEN is legal;
- regenerated tlast with a length-error flag;
- a history flush.

## Interface
- DATA_W, 8, sample width in bits (≥1)
- PKT_LEN, 8, samples per packet (≥2)
- OVERLAP_K, 3, overlap depth (1 ≤ OVERLAP_K ≤ PKT_LEN)

- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- input_tdata  in  DATA_W  input sample
- input_tvalid  in  1  input sample valid
- input_tready  out  1  block can accept a sample
- input_tlast  in  1  sender's end-of-packet marker
- output_tdata  out  DATA_W  overlap-added sample
- output_tvalid  out  1  output sample valid
- output_tready  in  1  downstream accepts
- output_tlast  out  1  regenerated end-of-packet
- flush  in  1  single-cycle pulse, clears history
- len_err  out  1  sticky, input tlast disagreed with PKT_LEN

## Operation
- **Beat acceptance**: a beat is accepted when input_tvalid && input_tready.
- **Position counter**: pos is $clog2(PKT_LEN) bits wide, resets to 0 and increments per accepted beat.
- **Head samples**: at pos < OVERLAP_K, out = in + hist_rd[pos], where hist_rd[pos] = bank_rd[pos] if valid_rd[pos], else 0.
- **Other samples**: at pos ≥ OVERLAP_K, out = in.
- **Tail capture**: at pos ≥ PKT_LEN−OVERLAP_K, the raw input_tdata is written to bank_wr[pos−(PKT_LEN−OVERLAP_K)] and that entry's valid bit is set.
- **Two banks** of OVERLAP_K × DATA_W with per-entry valid bits:
  - Reads always come from bank_rd and writes from bank_wr, so head and tail may overlap within one packet when K > PKT_LEN/2.
  - At end of packet the banks swap roles, and the new bank_wr has its valid bits cleared.
- **End of packet** is the accepted beat where input_tlast = 1 or pos = PKT_LEN−1, whichever comes first.
  - output_tlast = 1 on that beat; pos returns to 0; banks swap.
  - If input_tlast = 1 at pos < PKT_LEN−1 (early), len_err is set. Tail entries not yet written stay invalid, so they contribute 0.
  - If pos = PKT_LEN−1 and input_tlast = 0 (late/missing), len_err is set and output_tlast is still asserted.
- **Addition** is unsigned, DATA_W-bit result; overflow handling is set by the Configuration section.
- **flush**:
  - Clears all valid bits in both banks and sets pos = 0.
  - If a beat is accepted in the same cycle, that beat is output normally, but its pos, history and swap updates are discarded; flush wins.
  - len_err is not cleared by flush.
- **len_err** clears only on reset.

## Timing
- Single output register stage; latency is 1 cycle from input acceptance to output_tvalid. Throughput is 1 sample/cycle.
- input_tready = !output_tvalid || output_tready (combinational from output_tready).
- Output register:
  - Loads when input_tready is 1.
  - output_tvalid follows the input acceptance.
  - While output_tvalid && !output_tready, output_tdata and output_tlast are held stable.
- Reset values: output_tdata = 0, output_tvalid = 0, output_tlast = 0, len_err = 0, pos = 0, all valid bits = 0. The bank read/write select is reset to bank 0 = read. Bank data contents need not be reset.
- Reset mid-packet discards the in-flight beat and all history. The first packet after reset passes unmodified.
- tvalid must not depend on tready.

## Configuration
- OVERLAP_SAT_EN defined: the head sum saturates to 2^DATA_W−1 on carry-out.
- OVERLAP_SAT_EN undefined: the head sum wraps modulo 2^DATA_W. The carry bit is not generated.

## Test plan
- **Overlap-add, two packets**: DATA_W=8, PKT_LEN=8, K=3. Packet A 1..8 → output 1..8. Packet B 10..17 → output 16,18,20,13,14,15,16,17. output_tlast on the 8th beat of each; len_err=0.
- **Backpressure**: same stimulus with output_tready=0 for 5 cycles mid-packet B → output_tvalid held, output_tdata stable, input_tready=0, no sample lost or duplicated, identical output sequence.
- **Overflow**: tail 200,200,200 then head 100,0,0.
  - With OVERLAP_SAT_EN: output 255,200,200.
  - Without: output 44,200,200.
- **Early tlast**: input_tlast on beat 4 (pos=3) → output_tlast on that beat, len_err=1 (sticky). The next packet's head gets only tail entries written (none) → passes unmodified.
- **Flush, reset, full overlap**:
  - flush between packets → next packet 5,5,5,... unmodified.
  - reset asserted mid-packet → output_tvalid=0 asynchronously, history cleared.
  - With K=PKT_LEN=4, packets [1,2,3,4] then [1,1,1,1] → second output [2,3,4,5].

Source files
------------

// File: rtl/mod3_overlap_add.sv
// Overlap-add stage: the first OVERLAP_K samples of each packet are summed with the previous packet's tail.
// Define OVERLAP_SAT_EN to saturate head sums; otherwise they wrap modulo 2^DATA_W.
module mod3_overlap_add #(
  parameter int DATA_W    = 8,
  parameter int PKT_LEN   = 8,
  parameter int OVERLAP_K = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] input_tdata,
  input  logic              input_tvalid,
  output logic              input_tready,
  input  logic              input_tlast,
  output logic [DATA_W-1:0] output_tdata,
  output logic              output_tvalid,
  input  logic              output_tready,
  output logic              output_tlast,
  input  logic              flush,
  output logic              len_err
);

  localparam int POS_W = $clog2(PKT_LEN);
  localparam logic [POS_W-1:0] LAST_POS   = POS_W'(PKT_LEN - 1);
  localparam logic [POS_W-1:0] TAIL_START = POS_W'(PKT_LEN - OVERLAP_K);

  logic [POS_W-1:0]  pos;
  logic              rd_sel;  // 0: bank0 is read, bank1 is written
  logic [DATA_W-1:0] bank0 [OVERLAP_K];
  logic [DATA_W-1:0] bank1 [OVERLAP_K];
  logic [OVERLAP_K-1:0] valid0, valid1;

  logic              accept, eop, is_tail, len_bad;
  logic [POS_W-1:0]  tail_idx;
  logic [DATA_W-1:0] hist, head_sum;

  assign input_tready = !output_tvalid || output_tready;
  assign accept       = input_tvalid && input_tready;
  assign eop          = input_tlast || (pos == LAST_POS);
  assign len_bad      = input_tlast != (pos == LAST_POS);
  assign is_tail      = pos >= TAIL_START;
  assign tail_idx     = pos - TAIL_START;

  // Only indices below OVERLAP_K can match pos, so hist is zero outside the head.
  always_comb begin
    hist = '0;
    for (int unsigned i = 0; i < OVERLAP_K; i++) begin
      if (POS_W'(i) == pos) begin
        if (rd_sel) hist = valid1[i] ? bank1[i] : '0;
        else        hist = valid0[i] ? bank0[i] : '0;
      end
    end
  end

`ifdef OVERLAP_SAT_EN
  logic [DATA_W:0] sum_ext;
  assign sum_ext  = {1'b0, input_tdata} + {1'b0, hist};
  assign head_sum = sum_ext[DATA_W] ? '1 : sum_ext[DATA_W-1:0];
`else
  assign head_sum = input_tdata + hist;
`endif

  always_ff @(posedge clk) begin
    if (accept && !flush && is_tail) begin
      for (int unsigned i = 0; i < OVERLAP_K; i++) begin
        if (POS_W'(i) == tail_idx) begin
          if (rd_sel) bank0[i] <= input_tdata;
          else        bank1[i] <= input_tdata;
        end
      end
    end
  end

  // Tail writes land in the write bank while the end-of-packet clear hits the
  // read bank (the next write bank), so the two never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos    <= '0;
      rd_sel <= 1'b0;
      valid0 <= '0;
      valid1 <= '0;
    end else if (flush) begin
      pos    <= '0;
      valid0 <= '0;
      valid1 <= '0;
    end else if (accept) begin
      if (is_tail) begin
        for (int unsigned i = 0; i < OVERLAP_K; i++) begin
          if (POS_W'(i) == tail_idx) begin
            if (rd_sel) valid0[i] <= 1'b1;
            else        valid1[i] <= 1'b1;
          end
        end
      end
      if (eop) begin
        pos    <= '0;
        rd_sel <= !rd_sel;
        if (rd_sel) valid1 <= '0;
        else        valid0 <= '0;
      end else begin
        pos <= pos + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_err <= 1'b0;
    end else if (accept && len_bad) begin
      len_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      output_tdata  <= '0;
      output_tvalid <= 1'b0;
      output_tlast  <= 1'b0;
    end else if (input_tready) begin
      output_tvalid <= input_tvalid;
      if (input_tvalid) begin
        output_tdata <= head_sum;
        output_tlast <= eop;
      end
    end
  end

endmodule

// File: tb/tb_mod3_overlap_add.sv
// Self-checking bench for mod3_overlap_add: randomized and directed packets against a packet-level reference model.
module tb_mod3_overlap_add;
  localparam int DW = 8, PL = 8, K = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] input_tdata = '0;
  logic          input_tvalid = 1'b0, input_tlast = 1'b0;
  logic          input_tready;
  logic [DW-1:0] output_tdata;
  logic          output_tvalid, output_tlast, len_err;
  logic          output_tready = 1'b1;
  logic          flush = 1'b0;

  logic [7:0] c4_tdata = '0;
  logic       c4_tvalid = 1'b0, c4_tlast = 1'b0;
  logic       c4_tready, c4_ovalid, c4_olast, c4_len_err;
  logic [7:0] c4_odata;

  int checks = 0, passes = 0;
  int got_d[$]; bit got_l[$];
  int exp_d[$]; bit exp_l[$];
  int m_prev[$]; bit m_ok = 1'b0;

  always #5 clk = ~clk;

  mod3_overlap_add #(.DATA_W(DW), .PKT_LEN(PL), .OVERLAP_K(K)) dut (
    .clk(clk), .reset(reset),
    .input_tdata(input_tdata), .input_tvalid(input_tvalid), .input_tready(input_tready),
    .input_tlast(input_tlast),
    .output_tdata(output_tdata), .output_tvalid(output_tvalid), .output_tready(output_tready),
    .output_tlast(output_tlast), .flush(flush), .len_err(len_err)
  );

  mod3_overlap_add #(.DATA_W(8), .PKT_LEN(4), .OVERLAP_K(4)) dut4 (
    .clk(clk), .reset(reset),
    .input_tdata(c4_tdata), .input_tvalid(c4_tvalid), .input_tready(c4_tready),
    .input_tlast(c4_tlast),
    .output_tdata(c4_odata), .output_tvalid(c4_ovalid), .output_tready(1'b1),
    .output_tlast(c4_olast), .flush(1'b0), .len_err(c4_len_err)
  );

  // A handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (!reset && output_tvalid && output_tready) begin
      got_d.push_back(int'(output_tdata));
      got_l.push_back(output_tlast);
    end
  end

  function automatic int sat_add(input int a, input int b);
    int s = a + b;
`ifdef OVERLAP_SAT_EN
    return (s > (1 << DW) - 1) ? (1 << DW) - 1 : s;
`else
    return s % (1 << DW);
`endif
  endfunction

  // Head sample p pairs with sample PL-K+p of the previous packet, if that packet reached it.
  function automatic void model_pkt(input int d[$]);
    for (int p = 0; p < d.size(); p++) begin
      int v = d[p];
      int src = PL - K + p;
      if (p < K && m_ok && src < m_prev.size()) v = sat_add(v, m_prev[src]);
      exp_d.push_back(v);
      exp_l.push_back(p == d.size() - 1);
    end
    m_prev = d;
    m_ok = 1'b1;
  endfunction

  task automatic drive_beat(input int d, input bit l);
    int n = 0;
    input_tdata = DW'(d); input_tvalid = 1'b1; input_tlast = l;
    @(negedge clk);
    while (!input_tready && n < 100) begin n++; @(negedge clk); end
    if (!input_tready) begin
      checks++;
      $display("FAIL accept_timeout: input_tready=%0b after %0d cycles, required 1", input_tready, n);
    end
    @(posedge clk); #1;
    input_tvalid = 1'b0; input_tlast = 1'b0;
  endtask

  task automatic send_pkt(input int d[$], input bit last_final);
    model_pkt(d);
    for (int i = 0; i < d.size(); i++) drive_beat(d[i], last_final && (i == d.size() - 1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (got_d.size() < exp_d.size() && n < 60) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; input_tvalid = 1'b0; input_tlast = 1'b0; flush = 1'b0; c4_tvalid = 1'b0;
    output_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_queues();
    m_prev.delete(); m_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (output_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %0b required 0", output_tvalid); else passes++;
    checks++; if (output_tdata !== '0) $display("FAIL reset_tdata: got %0d required 0", output_tdata); else passes++;
    checks++; if (output_tlast !== 1'b0) $display("FAIL reset_tlast: got %0b required 0", output_tlast); else passes++;
    checks++; if (len_err !== 1'b0) $display("FAIL reset_len_err: got %0b required 0", len_err); else passes++;
    checks++; if (input_tready !== 1'b1) $display("FAIL reset_tready: got %0b required 1", input_tready); else passes++;
    do_reset();
  endtask

  task automatic test_two_packets();
    do_reset();
    send_pkt('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b1);
    send_pkt('{10, 11, 12, 13, 14, 15, 16, 17}, 1'b1);
    wait_drain();
    checks++; if (got_d.size() != exp_d.size()) $display("FAIL two_pkt_count: got %0d required %0d", got_d.size(), exp_d.size()); else passes++;
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL two_pkt[%0d]: got %0d/last%0b required %0d/last%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else passes++;
    end
    checks++; if (got_d.size() > 10 && got_d[8] !== 16) $display("FAIL two_pkt_head0: got %0d required 16", got_d[8]); else passes++;
    checks++; if (len_err !== 1'b0) $display("FAIL two_pkt_len_err: got %0b required 0", len_err); else passes++;
    clear_queues();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held; logic heldl;
    do_reset();
    fork
      begin
        send_pkt('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b1);
        send_pkt('{10, 11, 12, 13, 14, 15, 16, 17}, 1'b1);
      end
      begin
        repeat (11) @(posedge clk);
        #1 output_tready = 1'b0;
        @(negedge clk);
        held = output_tdata; heldl = output_tlast;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (output_tvalid !== 1'b1 || output_tdata !== held || output_tlast !== heldl || input_tready !== 1'b0)
            $display("FAIL bp_hold: valid=%0b data=%0d last=%0b in_rdy=%0b required 1/%0d/%0b/0",
                     output_tvalid, output_tdata, output_tlast, input_tready, held, heldl);
          else passes++;
        end
        @(posedge clk);
        #1 output_tready = 1'b1;
      end
    join
    wait_drain();
    checks++; if (got_d.size() != exp_d.size()) $display("FAIL bp_count: got %0d required %0d", got_d.size(), exp_d.size()); else passes++;
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL bp[%0d]: got %0d/last%0b required %0d/last%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else passes++;
    end
    clear_queues();
  endtask

  task automatic test_overflow();
    int head0;
`ifdef OVERLAP_SAT_EN
    head0 = 255;
`else
    head0 = 44;
`endif
    do_reset();
    send_pkt('{1, 2, 3, 4, 5, 200, 200, 200}, 1'b1);
    send_pkt('{100, 0, 0, 7, 7, 7, 7, 7}, 1'b1);
    wait_drain();
    checks++; if (got_d.size() != exp_d.size()) $display("FAIL ovf_count: got %0d required %0d", got_d.size(), exp_d.size()); else passes++;
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL ovf[%0d]: got %0d/last%0b required %0d/last%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else passes++;
    end
    checks++; if (got_d.size() > 9 && got_d[8] !== head0) $display("FAIL ovf_head0: got %0d required %0d", got_d[8], head0); else passes++;
    clear_queues();
  endtask

  task automatic test_late_tlast();
    do_reset();
    send_pkt('{9, 8, 7, 6, 5, 4, 3, 2}, 1'b0);
    wait_drain();
    checks++; if (got_d.size() != 8 || got_l[7] !== 1'b1) $display("FAIL late_tlast: count %0d required 8 with last on beat 8", got_d.size()); else passes++;
    checks++; if (len_err !== 1'b1) $display("FAIL late_len_err: got %0b required 1", len_err); else passes++;
    clear_queues();
  endtask

  task automatic test_early_tlast();
    do_reset();
    send_pkt('{11, 12, 13, 14, 15, 16, 17, 18}, 1'b1);
    wait_drain();
    checks++; if (len_err !== 1'b0) $display("FAIL early_pre_len_err: got %0b required 0", len_err); else passes++;
    send_pkt('{1, 2, 3, 4}, 1'b1);
    send_pkt('{20, 21, 22, 23, 24, 25, 26, 27}, 1'b1);
    wait_drain();
    checks++; if (got_d.size() != exp_d.size()) $display("FAIL early_count: got %0d required %0d", got_d.size(), exp_d.size()); else passes++;
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL early[%0d]: got %0d/last%0b required %0d/last%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else passes++;
    end
    checks++; if (len_err !== 1'b1) $display("FAIL early_len_err: got %0b required 1", len_err); else passes++;
    clear_queues();
  endtask

  task automatic test_flush();
    send_pkt('{50, 60, 70, 80, 90, 100, 110, 120}, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    m_ok = 1'b0;
    send_pkt('{5, 5, 5, 5, 5, 5, 5, 5}, 1'b1);
    wait_drain();
    checks++; if (got_d.size() != exp_d.size()) $display("FAIL flush_count: got %0d required %0d", got_d.size(), exp_d.size()); else passes++;
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL flush[%0d]: got %0d/last%0b required %0d/last%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else passes++;
    end
    checks++; if (len_err !== 1'b1) $display("FAIL flush_len_err: got %0b required 1", len_err); else passes++;
    clear_queues();
  endtask

  task automatic test_random();
    bit rnd_on = 1'b1;
    do_reset();
    fork
      begin
        for (int p = 0; p < 14; p++) begin
          int d[$];
          int len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, PL)) : PL;
          bit lf = (len < PL) ? 1'b1 : 1'($urandom_range(0, 1));
          for (int i = 0; i < len; i++) d.push_back(int'($urandom_range(0, (1 << DW) - 1)));
          send_pkt(d, lf);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1 output_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    output_tready = 1'b1;
    wait_drain();
    checks++; if (got_d.size() != exp_d.size()) $display("FAIL rnd_count: got %0d required %0d", got_d.size(), exp_d.size()); else passes++;
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL rnd[%0d]: got %0d/last%0b required %0d/last%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else passes++;
    end
    clear_queues();
  endtask

  task automatic test_reset_mid();
    int q[$];
    do_reset();
    for (int i = 0; i < PL; i++) q.push_back(int'($urandom_range(1, 200)));
    send_pkt(q, 1'b1);
    for (int i = 0; i < 3; i++) drive_beat(int'($urandom_range(1, 200)), 1'b0);
    input_tdata = 8'd77; input_tvalid = 1'b1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++; if (output_tvalid !== 1'b0) $display("FAIL reset_mid_tvalid: got %0b required 0", output_tvalid); else passes++;
    input_tvalid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    clear_queues(); m_prev.delete(); m_ok = 1'b0;
    q.delete();
    for (int i = 0; i < PL; i++) q.push_back(int'($urandom_range(1, 200)));
    send_pkt(q, 1'b1);
    wait_drain();
    checks++; if (got_d.size() != exp_d.size()) $display("FAIL reset_mid_count: got %0d required %0d", got_d.size(), exp_d.size()); else passes++;
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL reset_mid[%0d]: got %0d/last%0b required %0d/last%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else passes++;
    end
    clear_queues();
  endtask

  task automatic test_full_overlap();
    int seq[8] = '{1, 2, 3, 4, 1, 1, 1, 1};
    int ex[8]  = '{1, 2, 3, 4, 2, 3, 4, 5};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      c4_tdata = 8'(seq[i]); c4_tvalid = 1'b1; c4_tlast = (i % 4 == 3);
      @(posedge clk); #1;
      checks++;
      if (c4_ovalid !== 1'b1 || int'(c4_odata) !== ex[i] || c4_olast !== (i % 4 == 3))
        $display("FAIL full_overlap[%0d]: got %0d/valid%0b/last%0b required %0d/valid1/last%0b",
                 i, c4_odata, c4_ovalid, c4_olast, ex[i], (i % 4 == 3));
      else passes++;
    end
    c4_tvalid = 1'b0; c4_tlast = 1'b0;
  endtask

  initial begin
    test_reset();
    test_two_packets();
    test_backpressure();
    test_overflow();
    test_late_tlast();
    test_early_tlast();
    test_flush();
    test_random();
    test_reset_mid();
    test_full_overlap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
